// File: rtl/draw_pkg.sv
// Shared constants and state encoding for the sprite pixel pipeline feeding vga_adapter.
package draw_pkg;

    localparam int unsigned XW = 8;
    localparam int unsigned YW = 7;
    localparam int unsigned CW = 3;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;

    localparam logic [CW-1:0] BG_COLOUR = 3'b000;

    typedef enum logic [1:0] {
        IDLE,
        LATCH,
        DRAW,
        DONE
    } state_t;

endpackage

// File: rtl/sprite_draw_scheduler_if.sv
// Requester bus plus the vga_adapter pixel port of the sprite draw scheduler.
interface sprite_draw_scheduler_if #(
    parameter int unsigned NUM_REQ = 4
) ();

    logic [NUM_REQ-1:0]              req;
    logic [NUM_REQ-1:0]              req_erase;
    logic [draw_pkg::XW*NUM_REQ-1:0] req_x;
    logic [draw_pkg::YW*NUM_REQ-1:0] req_y;
    logic [draw_pkg::CW*NUM_REQ-1:0] req_colour;

    logic [NUM_REQ-1:0]              ack;
    logic                            busy;
    logic [draw_pkg::XW-1:0]         x_out;
    logic [draw_pkg::YW-1:0]         y_out;
    logic [draw_pkg::CW-1:0]         colour_out;
    logic                            plot;

    modport master (
        output req, req_erase, req_x, req_y, req_colour,
        input  ack, busy, x_out, y_out, colour_out, plot
    );

    modport slave (
        input  req, req_erase, req_x, req_y, req_colour,
        output ack, busy, x_out, y_out, colour_out, plot
    );

endinterface

// File: rtl/box_scan_counter.sv
// Row-major sweep of a BOX_SIZE x BOX_SIZE box, started on demand by clr.
module box_scan_counter #(
    parameter int unsigned BOX_SIZE = 11,
    parameter int unsigned BW       = (BOX_SIZE > 1) ? $clog2(BOX_SIZE) : 1
) (
    input  logic          clk,
    input  logic          reset_N,
    input  logic          clr,
    input  logic          en,
    output logic [BW-1:0] cx,
    output logic [BW-1:0] cy,
    output logic          last
);

    localparam logic [BW-1:0] MAX = BW'(BOX_SIZE - 1);

    assign last = (cx == MAX) && (cy == MAX);

    always_ff @(posedge clk) begin
        if (!reset_N || clr) begin
            cx <= '0;
            cy <= '0;
        end else if (en) begin
            if (cx == MAX) begin
                cx <= '0;
                cy <= (cy == MAX) ? '0 : cy + 1'b1;
            end else begin
                cx <= cx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sprite_draw_scheduler.sv
// Round-robin arbiter and box sweeper sharing one vga_adapter write port among sprites.
module sprite_draw_scheduler
    import draw_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned BOX_SIZE = 11
) (
    input  logic                   clk,
    input  logic                   reset_N,
    sprite_draw_scheduler_if.slave bus
);

    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned BW = (BOX_SIZE > 1) ? $clog2(BOX_SIZE) : 1;

    state_t            state, state_nx;
    logic [IW-1:0]     ptr, gnt, arb_idx;
    logic [IW:0]       cand;
    logic              arb_hit;

    logic [XW-1:0]     ox, sel_x;
    logic [YW-1:0]     oy, sel_y;
    logic [CW-1:0]     col, sel_c;
    logic              sel_erase;

    logic [BW-1:0]     cx, cy;
    logic              scan_last;
    logic [XW:0]       px;
    logic [YW:0]       py;

    logic [NUM_REQ-1:0] ack_d;
    logic               busy_d, plot_d;
    logic [XW-1:0]      x_d;
    logic [YW-1:0]      y_d;
    logic [CW-1:0]      c_d;

    box_scan_counter #(
        .BOX_SIZE (BOX_SIZE),
        .BW       (BW)
    ) u_scan (
        .clk     (clk),
        .reset_N (reset_N),
        .clr     (state == LATCH),
        .en      (state == DRAW),
        .cx      (cx),
        .cy      (cy),
        .last    (scan_last)
    );

    // First set request at or after ptr, wrapping past NUM_REQ-1.
    always_comb begin
        arb_hit = 1'b0;
        arb_idx = '0;
        cand    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr} + (IW+1)'(i);
            if (cand >= (IW+1)'(NUM_REQ))
                cand = cand - (IW+1)'(NUM_REQ);
            if (!arb_hit && bus.req[cand[IW-1:0]]) begin
                arb_hit = 1'b1;
                arb_idx = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        sel_x     = '0;
        sel_y     = '0;
        sel_c     = '0;
        sel_erase = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt == IW'(i)) begin
                sel_x     = bus.req_x[i*XW +: XW];
                sel_y     = bus.req_y[i*YW +: YW];
                sel_c     = bus.req_colour[i*CW +: CW];
                sel_erase = bus.req_erase[i];
            end
        end
    end

    // Sums carry one extra bit so off-screen pixels are clipped instead of wrapping.
    assign px = {1'b0, ox} + (XW+1)'(cx);
    assign py = {1'b0, oy} + (YW+1)'(cy);

    always_ff @(posedge clk) begin
        if (!reset_N) begin
            state          <= IDLE;
            ptr            <= '0;
            gnt            <= '0;
            ox             <= '0;
            oy             <= '0;
            col            <= '0;
            bus.ack        <= '0;
            bus.busy       <= 1'b0;
            bus.plot       <= 1'b0;
            bus.x_out      <= '0;
            bus.y_out      <= '0;
            bus.colour_out <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && arb_hit)
                gnt <= arb_idx;
            if (state == LATCH) begin
                ox  <= sel_x;
                oy  <= sel_y;
                col <= sel_erase ? BG_COLOUR : sel_c;
            end
            if (state == DONE)
                ptr <= (gnt == IW'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
            bus.ack        <= ack_d;
            bus.busy       <= busy_d;
            bus.plot       <= plot_d;
            bus.x_out      <= x_d;
            bus.y_out      <= y_d;
            bus.colour_out <= c_d;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (arb_hit) state_nx = LATCH;
            LATCH: state_nx = DRAW;
            DRAW:  if (scan_last) state_nx = DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Next values of the registered outputs; busy follows the state being entered.
    always_comb begin
        ack_d  = '0;
        busy_d = (state_nx != IDLE);
        plot_d = 1'b0;
        x_d    = bus.x_out;
        y_d    = bus.y_out;
        c_d    = bus.colour_out;
        if (state == DRAW) begin
            x_d    = px[XW-1:0];
            y_d    = py[YW-1:0];
            c_d    = col;
            plot_d = (px < (XW+1)'(SCREEN_W)) && (py < (YW+1)'(SCREEN_H));
        end
        if (state == DONE)
            ack_d = NUM_REQ'(1) << gnt;
    end

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Scoreboard bench for sprite_draw_scheduler: expected pixels and acks queued at stimulus time.
module tb_sprite_draw_scheduler;

    logic clk = 1'b0;
    logic reset_N;

    always #5 clk = ~clk;

    sprite_draw_scheduler_if #(.NUM_REQ(4)) bus ();

    sprite_draw_scheduler #(
        .NUM_REQ  (4),
        .BOX_SIZE (11)
    ) dut (
        .clk     (clk),
        .reset_N (reset_N),
        .bus     (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [17:0] exp_px[$];
    int          exp_ack[$];

    int cyc           = 0;
    int plots         = 0;
    int busy_cyc      = 0;
    int acks          = 0;
    int last_plot_cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Reference sweep: row-major, clipped pixels consume a slot but are not plotted.
    task automatic push_box(input int r, input int x, input int y, input logic [2:0] c, input logic e);
        for (int oy = 0; oy < 11; oy++) begin
            for (int ox = 0; ox < 11; ox++) begin
                int xs;
                int ys;
                xs = x + ox;
                ys = y + oy;
                if (xs < 160 && ys < 120)
                    exp_px.push_back({xs[7:0], ys[6:0], e ? 3'b000 : c});
            end
        end
        exp_ack.push_back(r);
    endtask

    task automatic set_req(input int r, input logic [7:0] x, input logic [6:0] y,
                           input logic [2:0] c, input logic e);
        bus.req_x[8*r +: 8]      = x;
        bus.req_y[7*r +: 7]      = y;
        bus.req_colour[3*r +: 3] = c;
        bus.req_erase[r]         = e;
        bus.req[r]               = 1'b1;
    endtask

    task automatic wait_ack(input int r, input int budget);
        for (int i = 0; i < budget; i++) begin
            step();
            if (bus.ack[r]) break;
        end
        check("ack_seen", 32'(bus.ack[r]), 1);
    endtask

    task automatic wait_plot(input int budget);
        for (int i = 0; i < budget; i++) begin
            step();
            if (bus.plot) break;
        end
        check("plot_seen", 32'(bus.plot), 1);
    endtask

    always @(negedge clk) begin
        logic [17:0] e;
        int          r;
        cyc++;
        if (bus.busy) busy_cyc++;
        if (bus.plot) begin
            plots++;
            last_plot_cyc = cyc;
            check("px_expected", 32'(exp_px.size() != 0), 1);
            if (exp_px.size() != 0) begin
                e = exp_px.pop_front();
                check("px", 32'({bus.x_out, bus.y_out, bus.colour_out}), 32'(e));
            end
        end
        if (bus.ack != '0) begin
            acks++;
            check("ack_expected", 32'(exp_ack.size() != 0), 1);
            if (exp_ack.size() != 0) begin
                r = exp_ack.pop_front();
                check("ack", 32'(bus.ack), 32'(4'b0001 << r));
            end
        end
    end

    initial begin
        int bp, bb, ba, c0, a1;
        reset_N        = 1'b0;
        bus.req        = '0;
        bus.req_erase  = '0;
        bus.req_x      = '0;
        bus.req_y      = '0;
        bus.req_colour = '0;
        repeat (3) step();
        check("rst_ack",    32'(bus.ack),        0);
        check("rst_busy",   32'(bus.busy),       0);
        check("rst_plot",   32'(bus.plot),       0);
        check("rst_x",      32'(bus.x_out),      0);
        check("rst_y",      32'(bus.y_out),      0);
        check("rst_colour", 32'(bus.colour_out), 0);
        reset_N = 1'b1;
        step();

        // Single box with latency and ack timing.
        bp = plots; bb = busy_cyc;
        push_box(0, 14, 99, 3'b100, 1'b0);
        set_req(0, 8'd14, 7'd99, 3'b100, 1'b0);
        c0 = cyc;
        wait_plot(10);
        check("t1_latency", 32'(cyc - c0), 3);
        wait_ack(0, 400);
        bus.req[0] = 1'b0;
        check("t1_ack_gap", 32'(cyc - last_plot_cyc), 1);
        check("t1_plots",   32'(plots - bp), 121);
        check("t1_busy",    32'(busy_cyc - bb), 123);

        // Round robin from reset: 0, then 2 ahead of a still-pending 0, then 0.
        reset_N = 1'b0;
        repeat (2) step();
        reset_N = 1'b1;
        bp = plots; ba = acks;
        push_box(0, 0, 0, 3'b001, 1'b0);
        push_box(2, 40, 20, 3'b110, 1'b0);
        push_box(0, 0, 0, 3'b001, 1'b0);
        set_req(0, 8'd0, 7'd0, 3'b001, 1'b0);
        set_req(2, 8'd40, 7'd20, 3'b110, 1'b0);
        wait_ack(0, 400);
        wait_ack(2, 400);
        bus.req[2] = 1'b0;
        wait_ack(0, 400);
        bus.req[0] = 1'b0;
        check("t2_acks",  32'(acks - ba), 3);
        check("t2_plots", 32'(plots - bp), 363);

        // Clipped box at the bottom-right corner.
        bp = plots; bb = busy_cyc;
        push_box(1, 155, 115, 3'b101, 1'b0);
        set_req(1, 8'd155, 7'd115, 3'b101, 1'b0);
        wait_ack(1, 400);
        bus.req[1] = 1'b0;
        check("t3_plots", 32'(plots - bp), 25);
        check("t3_busy",  32'(busy_cyc - bb), 123);

        // Erase paints background regardless of requested colour.
        bp = plots;
        push_box(1, 60, 50, 3'b111, 1'b1);
        set_req(1, 8'd60, 7'd50, 3'b111, 1'b1);
        wait_ack(1, 400);
        bus.req[1] = 1'b0;
        bus.req_erase[1] = 1'b0;
        check("t4_plots", 32'(plots - bp), 121);

        // Reset during the 50th plot aborts the box without an ack.
        bp = plots; ba = acks;
        push_box(2, 30, 30, 3'b011, 1'b0);
        set_req(2, 8'd30, 7'd30, 3'b011, 1'b0);
        for (int i = 0; i < 200; i++) begin
            if (plots - bp >= 50) break;
            step();
        end
        check("t5_at50", 32'(plots - bp), 50);
        reset_N    = 1'b0;
        bus.req[2] = 1'b0;
        step();
        check("t5_plot", 32'(bus.plot), 0);
        check("t5_busy", 32'(bus.busy), 0);
        check("t5_ack",  32'(bus.ack),  0);
        exp_px.delete();
        exp_ack.delete();
        reset_N = 1'b1;
        repeat (5) step();
        check("t5_no_ack", 32'(acks - ba), 0);
        bp = plots;
        push_box(2, 30, 30, 3'b011, 1'b0);
        set_req(2, 8'd30, 7'd30, 3'b011, 1'b0);
        wait_ack(2, 400);
        bus.req[2] = 1'b0;
        check("t5_plots", 32'(plots - bp), 121);

        // Requester holds req through ack and gets a back-to-back second box.
        bp = plots; ba = acks;
        push_box(3, 100, 10, 3'b010, 1'b0);
        push_box(3, 100, 10, 3'b010, 1'b0);
        set_req(3, 8'd100, 7'd10, 3'b010, 1'b0);
        wait_ack(3, 400);
        a1 = cyc;
        wait_plot(10);
        check("t6_restart", 32'(cyc - a1), 3);
        wait_ack(3, 400);
        bus.req[3] = 1'b0;
        check("t6_acks",  32'(acks - ba), 2);
        check("t6_plots", 32'(plots - bp), 242);

        repeat (5) step();
        check("px_left",  32'(exp_px.size()),  0);
        check("ack_left", 32'(exp_ack.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
